// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: one allocation per cycle to rename,
// up to two retire-side frees per cycle, with a sticky flag for frees dropped when full.
module phys_reg_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = $clog2(PHYS_REGS),
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_req,
  output logic                     alloc_grant,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic                     retire_valid1,
  input  logic [TAG_W-1:0]         retire_phys_reg1,
  input  logic                     retire_valid2,
  input  logic [TAG_W-1:0]         retire_phys_reg2,
  output logic                     free_list_empty,
  output logic [$clog2(DEPTH):0]   free_count,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [TAG_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             elig1, elig2;
  logic             acc1, acc2;
  logic [1:0]       n_push;
  logic [CNT_W-1:0] space;

  assign free_list_empty = (count_q == '0);
  assign alloc_grant     = alloc_req && !free_list_empty;
  assign alloc_tag       = entry_q[head_q];
  assign free_count      = count_q;
  assign overflow_err    = overflow_q;

  // Tag 0 is never returned to the list; space counts the slot vacated by this cycle's pop.
  always_comb begin
    entry_d    = entry_q;
    elig1      = retire_valid1 && (retire_phys_reg1 != '0);
    elig2      = retire_valid2 && (retire_phys_reg2 != '0);
    space      = CNT_W'(DEPTH) - count_q + CNT_W'(alloc_grant);
    acc1       = elig1 && (space != '0);
    acc2       = elig2 && (space > (acc1 ? CNT_W'(1) : CNT_W'(0)));
    n_push     = {1'b0, acc1} + {1'b0, acc2};
    tail_p1    = tail_q + PTR_W'(1);
    if (acc1) begin
      entry_d[tail_q] = retire_phys_reg1;
    end
    if (acc2) begin
      entry_d[acc1 ? tail_p1 : tail_q] = retire_phys_reg2;
    end
    head_d     = head_q + PTR_W'(alloc_grant);
    tail_d     = tail_q + PTR_W'(n_push);
    count_d    = count_q - CNT_W'(alloc_grant) + CNT_W'(n_push);
    overflow_d = overflow_q | (elig1 & ~acc1) | (elig2 & ~acc2);
  end

  // Reset image: every tag above the identity architectural mapping is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= TAG_W'(ARCH_REGS + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: table-driven vectors with hand-derived
// expectations, plus a FIFO reference model feeding a scoreboard of granted tags.
module tb_phys_reg_free_list;

  typedef struct {
    bit req;
    bit v1;
    int t1;
    bit v2;
    int t2;
    bit e_grant;
    int e_tag;
    int e_count;
    bit e_ovf;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       alloc_req;
  logic       alloc_grant;
  logic [5:0] alloc_tag;
  logic       retire_valid1;
  logic [5:0] retire_phys_reg1;
  logic       retire_valid2;
  logic [5:0] retire_phys_reg2;
  logic       free_list_empty;
  logic [5:0] free_count;
  logic       overflow_err;

  int n_tests = 0;
  int n_fail  = 0;
  int model_q[$];
  int exp_q[$];
  bit model_ovf;
  vec_t tbl[$];

  phys_reg_free_list dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alloc_req        (alloc_req),
    .alloc_grant      (alloc_grant),
    .alloc_tag        (alloc_tag),
    .retire_valid1    (retire_valid1),
    .retire_phys_reg1 (retire_phys_reg1),
    .retire_valid2    (retire_valid2),
    .retire_phys_reg2 (retire_phys_reg2),
    .free_list_empty  (free_list_empty),
    .free_count       (free_count),
    .overflow_err     (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(bit req, bit v1, int t1, bit v2, int t2,
                              bit eg, int et, int ec, bit eo);
    vec_t v;
    v.req = req; v.v1 = v1; v.t1 = t1; v.v2 = v2; v.t2 = t2;
    v.e_grant = eg; v.e_tag = et; v.e_count = ec; v.e_ovf = eo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    model_q.delete();
    exp_q.delete();
    for (int i = 32; i < 64; i++) model_q.push_back(i);
    model_ovf = 1'b0;
  endfunction

  // Reference behaviour: pop first, then accept eligible frees in slot order while room remains.
  function automatic void model_step(vec_t v);
    int space;
    if (v.req && model_q.size() > 0) void'(model_q.pop_front());
    space = 32 - model_q.size();
    if (v.v1 && v.t1 != 0) begin
      if (space > 0) begin model_q.push_back(v.t1); space--; end
      else model_ovf = 1'b1;
    end
    if (v.v2 && v.t2 != 0) begin
      if (space > 0) begin model_q.push_back(v.t2); space--; end
      else model_ovf = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    alloc_req        = v.req;
    retire_valid1    = v.v1;
    retire_phys_reg1 = 6'(v.t1);
    retire_valid2    = v.v2;
    retire_phys_reg2 = 6'(v.t2);
    #1;
    if (v.req && model_q.size() > 0) exp_q.push_back(model_q[0]);
    checkOutput("grant_model", int'(alloc_grant), int'(v.req && model_q.size() > 0));
    checkOutput("grant_vec", int'(alloc_grant), int'(v.e_grant));
    checkOutput("empty_model", int'(free_list_empty), int'(model_q.size() == 0));
    checkOutput("count_model", int'(free_count), model_q.size());
    if (alloc_grant) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL sb_tag: grant with tag %0d, expected no grant", alloc_tag);
      end else begin
        checkOutput("sb_tag", int'(alloc_tag), exp_q.pop_front());
      end
    end
    if (v.e_grant) checkOutput("tag_vec", int'(alloc_tag), v.e_tag);
    @(posedge clk);
    model_step(v);
    #1;
    checkOutput("count_vec", int'(free_count), v.e_count);
    checkOutput("ovf_vec", int'(overflow_err), int'(v.e_ovf));
    checkOutput("ovf_model", int'(overflow_err), int'(model_ovf));
  endtask

  task automatic check_reset_image(input string tag);
    checkOutput({tag, "_count"}, int'(free_count), 32);
    checkOutput({tag, "_tag"}, int'(alloc_tag), 32);
    checkOutput({tag, "_empty"}, int'(free_list_empty), 0);
    checkOutput({tag, "_grant"}, int'(alloc_grant), 0);
    checkOutput({tag, "_ovf"}, int'(overflow_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_req = 0; retire_valid1 = 0; retire_valid2 = 0;
    retire_phys_reg1 = '0; retire_phys_reg2 = '0;
    reset_n = 1'b0;
    #2;
    model_reset();
    check_reset_image("rst");
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    alloc_req = 0; retire_valid1 = 0; retire_valid2 = 0;
    retire_phys_reg1 = '0; retire_phys_reg2 = '0;
    model_reset();
    #12;
    check_reset_image("por");
    reset_n = 1'b1;

    // Drain all 32 reset tags in order, then one denied request.
    for (int k = 0; k < 33; k++) begin
      applyStimulus(mk(1, 0, 0, 0, 0, k < 32, 32 + k, (k < 32) ? 31 - k : 0, 0));
    end
    checkOutput("drained_empty", int'(free_list_empty), 1);

    tbl.push_back(mk(1, 1, 40, 1, 41, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 40, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 41, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 50, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 50, 0, 0));
    tbl.push_back(mk(0, 0, 33, 1, 34, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 34, 0, 0));
    tbl.push_back(mk(0, 1, 35, 0, 36, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 35, 0, 0));
    tbl.push_back(mk(0, 1, 10, 1, 11, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 12, 1, 13, 0, 0, 4, 0));
    tbl.push_back(mk(0, 1, 14, 0, 0, 0, 0, 5, 0));
    tbl.push_back(mk(1, 1, 20, 1, 21, 1, 10, 6, 0));
    tbl.push_back(mk(1, 1, 22, 1, 23, 1, 11, 7, 0));
    tbl.push_back(mk(1, 1, 24, 1, 25, 1, 12, 8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 13, 7, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 14, 6, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 20, 5, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 21, 4, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 22, 3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 23, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 24, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 25, 0, 0));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Full list: frees dropped, sticky error; pop plus two frees keeps only slot 1.
    do_reset();
    applyStimulus(mk(0, 1, 45, 1, 46, 0, 0, 32, 1));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 32, 1));
    applyStimulus(mk(1, 1, 47, 1, 48, 1, 32, 32, 1));

    // Ten grants and three frees, then an asynchronous reset between edges.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(mk(1, 0, 0, 0, 0, 1, 33 + k, 31 - k, 1));
    end
    applyStimulus(mk(0, 1, 3, 1, 4, 0, 0, 24, 1));
    applyStimulus(mk(0, 1, 5, 0, 0, 0, 0, 25, 1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_image("async");
    #1;
    reset_n = 1'b1;
    applyStimulus(mk(1, 0, 0, 0, 0, 1, 32, 31, 0));
    applyStimulus(mk(1, 0, 0, 0, 0, 1, 33, 30, 0));

    checkOutput("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular free list of physical register tags for the rename stage. It is the consumer end of the ROB retire path: up to two tags per cycle arrive on `retire_valid1/2` with `retire_phys_reg1/2` (driven from the ROB `free_oldDest_1/2`). It is also the supplier of new destination tags to rename, at most one allocation per cycle. At reset it holds every physical register not covered by the identity architectural mapping.

## Interface
- `PHYS_REGS`, 64: number of physical registers.
- `ARCH_REGS`, 32: number of architectural registers. Tags 0..ARCH_REGS-1 are mapped at reset.
- `TAG_W`, 6: tag width; equals clog2(PHYS_REGS).
- `DEPTH`, PHYS_REGS-ARCH_REGS (32): list capacity.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `alloc_req` in 1: rename requests one tag this cycle.
- `alloc_grant` out 1: `alloc_req && !free_list_empty` (combinational).
- `alloc_tag` out TAG_W: tag at head. Meaningful only when `alloc_grant`=1.
- `retire_valid1` in 1: free slot 1 valid.
- `retire_phys_reg1` in TAG_W: tag to free, slot 1.
- `retire_valid2` in 1: free slot 2 valid.
- `retire_phys_reg2` in TAG_W: tag to free, slot 2.
- `free_list_empty` out 1: count == 0.
- `free_count` out clog2(DEPTH)+1: number of tags held, 0..DEPTH.
- `overflow_err` out 1: sticky; a valid free was dropped because the list was full.

## Operation
- Storage: DEPTH x TAG_W array, `head` and `tail` pointers of clog2(DEPTH) bits, plus `count`.
- Pointers wrap modulo DEPTH (natural wrap for power-of-two DEPTH).
- Reset:
  - `entry[i]` = ARCH_REGS+i.
  - `head` = 0, `tail` = 0, `count` = DEPTH.
  - Outputs: `free_list_empty`=0, `free_count`=32, `alloc_tag`=32, `alloc_grant`=0 (until req), `overflow_err`=0.
- Pop: when `alloc_grant`, head advances by 1.
- Push eligibility: a slot pushes only if its valid is set and its tag != 0. Physical register 0 is never freed, and such frees are silently ignored, with no error.
- Push order: slot 1 is written at `tail`, then slot 2 at `tail+1`. If only slot 2 is eligible, it is written at `tail`. Tail advances by the number of accepted pushes.
- Capacity: space = DEPTH - count + pop.
  - Pushes are accepted in slot order while space remains.
  - Any eligible push beyond space is dropped and sets `overflow_err`.
  - `overflow_err` clears only on reset.
- Count update: count_next = count - pop + accepted_pushes. It never leaves 0..DEPTH.
- No same-cycle bypass. A tag freed in cycle N is allocatable no earlier than cycle N+1. A request while empty is denied even if frees arrive that cycle.
- No duplicate-free detection. Uniqueness is guaranteed by the ROB.

## Timing
- `alloc_tag`, `alloc_grant` and `free_list_empty` are combinational from registered state (plus `alloc_req` for grant). Rename uses them in the same cycle.
- All state updates on the rising `clk` edge.
- Reset asserted mid-operation: restores the full reset image asynchronously. The first grant is possible in the first cycle after `reset_n` rises.
- Simultaneous pop plus two pushes at count == DEPTH: the pop frees one slot. Slot 1 is accepted, slot 2 is dropped, `overflow_err` is set, and count stays DEPTH.
- Pop plus push at count == 0: the pop is denied, the push is accepted, and count becomes 1.

## Test plan
- Reset, then `alloc_req` held 33 cycles:
  - Grants give tags 32,33,...,63 in order.
  - Cycle 33: `alloc_grant`=0, `free_list_empty`=1, `free_count`=0.
- From empty: free 40 (slot 1) and 41 (slot 2) in one cycle with `alloc_req`=1.
  - Same cycle: no grant.
  - Next two cycles: grants give 40 then 41, then empty.
- From count=5, each cycle for 3 cycles: alloc plus two valid frees. `free_count` goes 6, 7, 8, and freed tags emerge in FIFO order after the residual entries.
- Free with tag 0 on slot 1 and tag 50 on slot 2 while count=0: 50 is written, `free_count`=1, `overflow_err`=0.
- At count=32 (post-reset), free 45 and 46 with no alloc: both dropped, `overflow_err`=1 and stays 1, `free_count`=32.
- After 10 grants and 3 frees, pulse `reset_n` low mid-cycle: outputs return to the reset image immediately, and the next grants start again at 32.
